// File: rtl/pcie_ctrl_arb_pkg.sv
// pcie_ctrl_pkg: state encoding and sizing shared by the PCIE controller slice
package pcie_ctrl_pkg;
  localparam int NUM_FIFOS = 4;
  localparam int UMBRALES_L_H = 8;
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/pcie_ctrl_arb_if.sv
// pcie_ctrl_arb_if: FIFO status, threshold and pop/backpressure bundle of the controller
interface pcie_ctrl_arb_if;
  import pcie_ctrl_pkg::*;
  logic                    init;
  logic [UMBRALES_L_H-1:0] umbral_L_in, umbral_H_in, umbral_L, umbral_H;
  logic [NUM_FIFOS-1:0]    fifo_empty, fifo_almost_full, fifo_error, dest_ready, pop;
  logic                    pause;
  logic [2:0]              estado;
  logic                    idle_out, active_out, error_out;
  modport master (
    output init, umbral_L_in, umbral_H_in, fifo_empty, fifo_almost_full, fifo_error, dest_ready,
    input  umbral_L, umbral_H, pop, pause, estado, idle_out, active_out, error_out
  );
  modport slave (
    input  init, umbral_L_in, umbral_H_in, fifo_empty, fifo_almost_full, fifo_error, dest_ready,
    output umbral_L, umbral_H, pop, pause, estado, idle_out, active_out, error_out
  );
endinterface

// File: rtl/pcie_ctrl_arb_rr.sv
// rr_arbiter_4: combinational one-hot round-robin grant with a registered last-grant pointer
module rr_arbiter_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] eligible,
  output logic [3:0] grant
);
  logic [1:0] pointer, idx, sel;
  // Scan farthest-to-nearest after the pointer so the nearest eligible index wins.
  always_comb begin
    grant = '0;
    sel = pointer;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = pointer + 2'(k + 1);
      if (enable && eligible[idx]) begin
        grant = 4'b0001 << idx;
        sel = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pointer <= 2'd3;
    else if (|grant) pointer <= sel;
endmodule

// File: rtl/pcie_ctrl_arb.sv
// pcie_ctrl_arb: threshold loading, RESET/INIT/IDLE/ACTIVE/ERROR sequencing, pop arbitration and pause
module pcie_ctrl_arb
  import pcie_ctrl_pkg::*;
(
  input logic             clk,
  input logic             reset,
  pcie_ctrl_arb_if.slave  bus
);
  state_t state, state_nx;
  logic   arb_en;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= S_RESET;
      bus.umbral_L <= '0;
      bus.umbral_H <= '0;
      bus.pause    <= 1'b1;
      bus.idle_out <= 1'b0;
      bus.active_out <= 1'b0;
      bus.error_out  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) begin
        bus.umbral_L <= bus.umbral_L_in;
        bus.umbral_H <= bus.umbral_H_in;
      end
      bus.pause      <= (state == S_IDLE || state == S_ACTIVE) ? |bus.fifo_almost_full : 1'b1;
      bus.idle_out   <= state_nx == S_IDLE;
      bus.active_out <= state_nx == S_ACTIVE;
      bus.error_out  <= state_nx == S_ERROR;
    end
  // Error beats init, which beats the per-state moves; ERROR only leaves via reset.
  always_comb
    state_nx = state == S_RESET ? S_INIT :
               (state == S_ERROR || |bus.fifo_error) ? S_ERROR :
               bus.init ? S_INIT :
               state == S_INIT ? (bus.umbral_L_in < bus.umbral_H_in ? S_IDLE : S_ERROR) :
               &bus.fifo_empty ? S_IDLE : S_ACTIVE;
  always_comb begin
    arb_en = state == S_ACTIVE && !(|bus.fifo_error);
    bus.estado = state;
  end
  rr_arbiter_4 u_rr (
    .clk      (clk),
    .reset    (reset),
    .enable   (arb_en),
    .eligible (~bus.fifo_empty & bus.dest_ready),
    .grant    (bus.pop)
  );
endmodule

// File: tb/tb_pcie_ctrl_arb.sv
// tb_pcie_ctrl_arb: directed stimulus with a pop scoreboard drained by a negedge monitor
module tb_pcie_ctrl_arb;
  import pcie_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  pcie_ctrl_arb_if bus();
  pcie_ctrl_arb dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic [3:0] e);
    if (e != 4'b0) exp_q.push_back(e);
    cyc(1);
  endtask
  always @(negedge clk)
    if (bus.pop !== 4'b0) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {28'b0, bus.pop}, 32'h0);
      else chk("pop", {28'b0, bus.pop}, {28'b0, exp_q.pop_front()});
    end
  task automatic rst_pulse();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_estado_async", {29'b0, bus.estado}, 32'd0);
    chk("rst_pop", {28'b0, bus.pop}, 32'd0);
    cyc(2);
    chk("rst_umbral_L", {24'b0, bus.umbral_L}, 32'd0);
    chk("rst_umbral_H", {24'b0, bus.umbral_H}, 32'd0);
    chk("rst_pause", {31'b0, bus.pause}, 32'd1);
    chk("rst_decodes", {29'b0, bus.idle_out, bus.active_out, bus.error_out}, 32'd0);
    reset = 1'b1;
  endtask
  task automatic init_seq(input logic [7:0] l, input logic [7:0] h);
    bus.init = 1'b1;
    bus.umbral_L_in = l;
    bus.umbral_H_in = h;
    cyc(2);
    chk("init_estado", {29'b0, bus.estado}, 32'd1);
    bus.init = 1'b0;
    cyc(1);
  endtask
  initial begin
    int bad;
    bus.init = 1'b0;
    bus.umbral_L_in = '0;
    bus.umbral_H_in = '0;
    bus.fifo_empty = 4'hf;
    bus.fifo_almost_full = 4'h0;
    bus.fifo_error = 4'h0;
    bus.dest_ready = 4'hf;
    // good thresholds reach IDLE, pause drops one cycle later
    rst_pulse();
    init_seq(8'd2, 8'd6);
    chk("t1_estado", {29'b0, bus.estado}, 32'd2);
    chk("t1_decodes", {29'b0, bus.idle_out, bus.active_out, bus.error_out}, 32'b100);
    chk("t1_umbral_L", {24'b0, bus.umbral_L}, 32'd2);
    chk("t1_umbral_H", {24'b0, bus.umbral_H}, 32'd6);
    chk("t1_pause_still_high", {31'b0, bus.pause}, 32'd1);
    cyc(1);
    chk("t1_pause_low", {31'b0, bus.pause}, 32'd0);
    // full round robin
    bus.fifo_empty = 4'h0;
    cyc(1);
    chk("t3_estado", {29'b0, bus.estado}, 32'd3);
    chk("t3_active_out", {31'b0, bus.active_out}, 32'd1);
    tick(4'b0001); tick(4'b0010); tick(4'b0100); tick(4'b1000); tick(4'b0001);
    // partial eligibility
    bus.fifo_empty = 4'b1010;
    bus.dest_ready = 4'b1011;
    tick(4'b0001); tick(4'b0001); tick(4'b0001);
    bus.dest_ready = 4'b1111;
    tick(4'b0100); tick(4'b0001); tick(4'b0100); tick(4'b0001);
    bus.fifo_empty = 4'hf;
    @(negedge clk);
    chk("t4_pop_all_empty", {28'b0, bus.pop}, 32'd0);
    cyc(1);
    chk("t4_back_to_idle", {29'b0, bus.estado}, 32'd2);
    // almost-full backpressure while pops continue
    bus.fifo_empty = 4'h0;
    cyc(1);
    chk("t5_estado", {29'b0, bus.estado}, 32'd3);
    chk("t5_pause_before", {31'b0, bus.pause}, 32'd0);
    bus.fifo_almost_full = 4'b1000;
    tick(4'b0010);
    chk("t5_pause_set", {31'b0, bus.pause}, 32'd1);
    bus.fifo_almost_full = 4'b0000;
    tick(4'b0100);
    chk("t5_pause_clear", {31'b0, bus.pause}, 32'd0);
    tick(4'b1000);
    // fifo error kills the grant and latches ERROR
    tick(4'b0001);
    bus.fifo_error = 4'b0010;
    @(negedge clk);
    chk("t6_pop_on_error", {28'b0, bus.pop}, 32'd0);
    cyc(1);
    bus.fifo_error = 4'b0000;
    chk("t6_estado_error", {29'b0, bus.estado}, 32'd4);
    chk("t6_decodes", {29'b0, bus.idle_out, bus.active_out, bus.error_out}, 32'b001);
    cyc(1);
    chk("t6_pause_error", {31'b0, bus.pause}, 32'd1);
    chk("t6_pop_in_error", {28'b0, bus.pop}, 32'd0);
    // bad thresholds go to a sticky ERROR
    bus.fifo_empty = 4'hf;
    rst_pulse();
    init_seq(8'd6, 8'd2);
    chk("t2_estado", {29'b0, bus.estado}, 32'd4);
    chk("t2_error_out", {31'b0, bus.error_out}, 32'd1);
    chk("t2_pause", {31'b0, bus.pause}, 32'd1);
    bad = 0;
    bus.fifo_empty = 4'h0;
    bus.umbral_L_in = 8'd1;
    bus.umbral_H_in = 8'd9;
    for (int i = 0; i < 20; i++) begin
      bus.init = i[0];
      cyc(1);
      if (bus.estado != 3'd4 || bus.pop != 4'b0 || !bus.pause) bad++;
    end
    chk("t2_error_sticky", bad, 32'd0);
    chk("t2_umbral_L_held", {24'b0, bus.umbral_L}, 32'd6);
    chk("t2_umbral_H_held", {24'b0, bus.umbral_H}, 32'd2);
    bus.init = 1'b0;
    bus.fifo_empty = 4'hf;
    rst_pulse();
    // async reset in the middle of ACTIVE
    init_seq(8'd2, 8'd6);
    bus.fifo_empty = 4'h0;
    cyc(1);
    tick(4'b0001);
    tick(4'b0010);
    reset = 1'b0;
    #1;
    chk("t6_pop_async_reset", {28'b0, bus.pop}, 32'd0);
    chk("t6_estado_async_reset", {29'b0, bus.estado}, 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
